// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per req/rdy handshake, issues it to decode
// and redirects on jump/branch/halt. Optional retired-instruction counter under FETCH_INSTR_COUNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        Branch,
   input  logic        branch_cond,
   input  logic [31:0] jr_target,
   input  logic        Halted,
   output logic        halted,
   output logic        fault,
`ifdef FETCH_INSTR_COUNT_EN
   output logic [31:0] retired_count,
`endif
   output logic [1:0]  dbg_state
);

   // Handshake: imem_req is held while in FETCH; the word is taken in the cycle imem_rdy is high.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [31:0] TIMEOUT_LIMIT = IMEM_TIMEOUT[31:0];

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;
   logic        r_fault;
   logic [31:0] r_cnt;

   state_t      w_next_state;
   logic [31:0] w_next_pc;
   logic [31:0] w_next_cnt;
   logic        w_capture;
   logic        w_fault_set;
   logic        w_retire;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic        w_unused;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_unused   = ^jr_target[1:0];

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_cnt   = r_cnt;
      w_capture    = 1'b0;
      w_fault_set  = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (imem_rdy) begin
               w_capture    = 1'b1;
               w_next_cnt   = 32'd0;
               w_next_state = S_ISSUE;
            end else if (TIMEOUT_LIMIT != 32'd0) begin
               w_next_cnt = r_cnt + 32'd1;
               if (w_next_cnt == TIMEOUT_LIMIT) begin
                  w_fault_set  = 1'b1;
                  w_next_state = S_HALT;
               end
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               w_retire = 1'b1;
               if (Halted) begin
                  w_next_state = S_HALT;
               end else begin
                  w_next_state = S_FETCH;
                  if (Jump && JumpReg)
                     w_next_pc = {jr_target[31:2], 2'b00};
                  else if (Jump)
                     w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
                  else if (Branch && branch_cond)
                     w_next_pc = w_pc_plus4 + w_br_off;
                  else
                     w_next_pc = w_pc_plus4;
               end
            end
         end
         S_HALT: w_next_state = S_HALT;
         default: w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_cnt   <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         r_cnt   <= w_next_cnt;
         r_valid <= (w_next_state == S_ISSUE);
         if (w_capture)
            r_instr <= imem_rdata;
         if (w_fault_set)
            r_fault <= 1'b1;
      end
   end

`ifdef FETCH_INSTR_COUNT_EN
   logic [31:0] r_retired;

   always_ff @(posedge clk) begin
      if (rst)
         r_retired <= 32'd0;
      else if (w_retire && (r_retired != 32'hFFFF_FFFF))
         r_retired <= r_retired + 32'd1;
   end

   assign retired_count = r_retired;
`endif

   // Request is dropped combinationally during reset so an in-flight fetch is abandoned.
   assign imem_req    = (r_state == S_FETCH) && !rst;
   assign imem_addr   = {r_pc[31:2], 2'b00};
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign func        = r_instr[5:0];
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign halted      = (r_state == S_HALT);
   assign fault       = r_fault;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC=0x100, IMEM_TIMEOUT=4).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        stall = 1'b0;
   logic        Jump = 1'b0;
   logic        JumpReg = 1'b0;
   logic        Branch = 1'b0;
   logic        branch_cond = 1'b0;
   logic [31:0] jr_target = 32'd0;
   logic        Halted = 1'b0;
   logic        halted;
   logic        fault;
   logic [1:0]  dbg_state;
`ifdef FETCH_INSTR_COUNT_EN
   logic [31:0] retired_count;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(32'h100), .IMEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .func(func), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
      .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .branch_cond(branch_cond),
      .jr_target(jr_target), .Halted(Halted), .halted(halted), .fault(fault),
`ifdef FETCH_INSTR_COUNT_EN
      .retired_count(retired_count),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      stall = 0; Jump = 0; JumpReg = 0; Branch = 0; branch_cond = 0; Halted = 0; jr_target = 0;
   endtask

   task automatic do_reset();
      clear_ctrl();
      imem_rdy = 0; imem_rdata = 0;
      rst = 1;
      step();
      step();
      rst = 0;
      #1;
   endtask

   // Precondition: DUT in FETCH. Returns with the word issued (ISSUE).
   task automatic fetch_word(input logic [31:0] w);
      imem_rdy = 1; imem_rdata = w;
      step();
      imem_rdy = 0; imem_rdata = 0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1; imem_rdy = 1; imem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_low got=%b exp=0", imem_req); end
      do_reset();
      checks++;
      if (pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=00000100", pc); end
      checks++;
      if (instr !== 32'd0 || instr_valid !== 1'b0) begin
         failures++; $display("FAIL reset_instr got=%h/%b exp=00000000/0", instr, instr_valid);
      end
      checks++;
      if (halted !== 1'b0 || fault !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b exp=00", halted, fault);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || dbg_state !== 2'd0) begin
         failures++; $display("FAIL reset_fetch got=%b/%h/%0d exp=1/00000100/0", imem_req, imem_addr, dbg_state);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_a;
      do_reset();
      imem_rdy = 1; imem_rdata = 32'h8C00_0025;
      for (int i = 0; i < 3; i++) begin
         exp_a = 32'h100 + 32'(4 * i);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_a || instr_valid !== 1'b0) begin
            failures++; $display("FAIL seq_fetch got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, instr_valid, exp_a);
         end
         if (i == 2) imem_rdy = 1;
         step();
         if (i == 2) imem_rdy = 0;
         checks++;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_a || pc_plus4 !== exp_a + 32'd4) begin
            failures++; $display("FAIL seq_issue got=%b/%b/%h/%h exp=1/0/%h/%h", instr_valid, imem_req, pc, pc_plus4, exp_a, exp_a + 32'd4);
         end
         step();
      end
      checks++;
      if (instr !== 32'h8C00_0025 || opcode !== 6'h23 || func !== 6'h25) begin
         failures++; $display("FAIL seq_fields got=%h/%h/%h exp=8c000025/23/25", instr, opcode, func);
      end
      checks++;
      if (imem_addr !== 32'h10C || imem_req !== 1'b1) begin
         failures++; $display("FAIL seq_next got=%h exp=0000010c", imem_addr);
      end
   endtask

   task automatic test_jump();
      do_reset();
      fetch_word(32'h0800_0040);
      checks++;
      if (opcode !== 6'h02 || pc !== 32'h100) begin
         failures++; $display("FAIL jump_issue got=%h/%h exp=02/00000100", opcode, pc);
      end
      Jump = 1; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
         failures++; $display("FAIL jump_target0 got=%h exp=00000100", imem_addr);
      end
      fetch_word(32'h0800_0400);
      Jump = 1; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h1000) begin failures++; $display("FAIL jump_target1 got=%h exp=00001000", imem_addr); end
   endtask

   task automatic test_jr();
      do_reset();
      fetch_word(32'h0000_0008);
      Jump = 1; JumpReg = 1; jr_target = 32'h0000_2003;
      step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h2000 || pc !== 32'h2000) begin
         failures++; $display("FAIL jr_target got=%h exp=00002000", imem_addr);
      end
   endtask

   task automatic test_branch();
      do_reset();
      fetch_word(32'h0800_0080);
      Jump = 1; step(); clear_ctrl();
      fetch_word(32'h1000_FFFE);
      Branch = 1; branch_cond = 1; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h1FC) begin failures++; $display("FAIL branch_taken got=%h exp=000001fc", imem_addr); end
      fetch_word(32'h0800_0080);
      Jump = 1; step(); clear_ctrl();
      fetch_word(32'h1000_FFFE);
      Branch = 1; branch_cond = 0; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h204) begin failures++; $display("FAIL branch_not_taken got=%h exp=00000204", imem_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      fetch_word(32'h0800_0400);
      Jump = 1; stall = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (pc !== 32'h100 || instr !== 32'h0800_0400 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++; $display("FAIL stall_hold got=%h/%h/%b/%b exp=00000100/08000400/1/0", pc, instr, instr_valid, imem_req);
         end
      end
      stall = 0; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'h1000 || imem_req !== 1'b1) begin
         failures++; $display("FAIL stall_release got=%h exp=00001000", imem_addr);
      end
   endtask

   task automatic test_halt();
      do_reset();
      fetch_word(32'h0800_0400);
      Halted = 1; Jump = 1; step(); clear_ctrl();
      imem_rdy = 1; imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            failures++; $display("FAIL halt_hold got=%b/%b/%b/%b exp=1/0/0/0", halted, imem_req, instr_valid, fault);
         end
         step();
      end
      imem_rdy = 0;
      checks++;
      if (instr !== 32'h0800_0400) begin failures++; $display("FAIL halt_instr got=%h exp=08000400", instr); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (fault !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL timeout_early got=%b/%b/%b exp=0/0/1", fault, halted, imem_req);
         end
      end
      step();
      checks++;
      if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
         failures++; $display("FAIL timeout_fault got=%b/%b/%b exp=1/1/0", fault, halted, imem_req);
      end
      step();
      checks++;
      if (fault !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", fault); end
      do_reset();
      checks++;
      if (fault !== 1'b0 || halted !== 1'b0) begin
         failures++; $display("FAIL timeout_clear got=%b/%b exp=0/0", fault, halted);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      fetch_word(32'd0);
      Jump = 1; JumpReg = 1; jr_target = 32'hFFFF_FFFF; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jr got=%h exp=fffffffc", imem_addr); end
      fetch_word(32'h1000_0001);
      checks++;
      if (pc_plus4 !== 32'd0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
      Branch = 1; branch_cond = 1; step(); clear_ctrl();
      checks++;
      if (imem_addr !== 32'd4) begin failures++; $display("FAIL wrap_branch got=%h exp=00000004", imem_addr); end
      fetch_word(32'd0);
      Jump = 1; JumpReg = 1; jr_target = 32'hFFFF_FFFC; step(); clear_ctrl();
      fetch_word(32'd0);
      step();
      checks++;
      if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin
         failures++; $display("FAIL wrap_seq got=%h exp=00000000", imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      fetch_word(32'h0800_0400);
      Jump = 1; step(); clear_ctrl();
      step();
      rst = 1; imem_rdy = 1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", imem_req); end
      step();
      rst = 0; imem_rdy = 0; imem_rdata = 0;
      #1;
      checks++;
      if (pc !== 32'h100 || instr_valid !== 1'b0 || instr !== 32'd0 || dbg_state !== 2'd0 || imem_req !== 1'b1) begin
         failures++; $display("FAIL midrst_state got=%h/%b/%h/%0d exp=00000100/0/00000000/0", pc, instr_valid, instr, dbg_state);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_jr();
      test_branch();
      test_stall();
      test_halt();
      test_timeout();
      test_wrap();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and fetches one word at a time from instruction memory using a req/rdy handshake.
- Presents the instruction, with its opcode and func fields split out, to decode.
- Takes Jump/JumpReg/Branch/Halted back from the control unit and the branch condition from the ALU, computes the next PC, and stops fetching after a halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_TIMEOUT, 255, max cycles waiting on imem_rdy before fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word address of request (bits [1:0] always 0)
- imem_rdy  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction currently issued to decode
- opcode  out  6  instr[31:26]
- func  out  6  instr[5:0]
- instr_valid  out  1  instr/opcode/func valid for decode
- pc  out  32  address of instr
- pc_plus4  out  32  pc+4, used as link address for JAL
- stall  in  1  downstream holds the current instruction (multi-cycle ALU/FPU op)
- Jump  in  1  from control unit
- JumpReg  in  1  from control unit
- Branch  in  1  from control unit
- branch_cond  in  1  ALU zero flag qualifying Branch
- jr_target  in  32  rs register value for JR
- Halted  in  1  from control unit
- halted  out  1  fetch has stopped permanently
- fault  out  1  imem timeout occurred; sticky

Behaviour:
- Reset (rst=1 at edge):
  - state=FETCH, pc=RESET_PC.
  - instr=0, instr_valid=0, halted=0, fault=0, imem_req=0, timeout counter=0.
  - Reset asserted mid-fetch abandons the request; an imem_rdy in that cycle is ignored.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_rdy: instr<=imem_rdata, instr_valid<=1, go to ISSUE. Fetch latency is 1 cycle minimum after the request.
- State ISSUE:
  - imem_req=0, instr_valid=1.
  - Control inputs are sampled only in ISSUE with stall=0. stall=1 holds instr, pc and state unchanged.
  - With stall=0, first match wins:
    1. Halted=1: go to HALT, instr_valid<=0.
    2. Jump&JumpReg: pc<={jr_target[31:2],2'b00}.
    3. Jump: pc<={pc_plus4[31:28],instr[25:0],2'b00}.
    4. Branch&branch_cond: pc<=pc_plus4+{{14{instr[15]}},instr[15:0],2'b00}.
    5. Otherwise: pc<=pc_plus4.
  - Then instr_valid<=0 and go to FETCH.
- No branch delay slot; one bubble cycle per instruction minimum (no overlap).
- Arithmetic is 32-bit modulo. pc=32'hFFFF_FFFC with sequential next wraps to 0. Branch targets wrap likewise.
- State HALT:
  - halted=1, imem_req=0, instr_valid=0; only rst leaves HALT.
  - An imem_rdy arriving in HALT is ignored.
- Timeout (IMEM_TIMEOUT>0):
  - Counter increments each FETCH cycle without imem_rdy and clears on imem_rdy.
  - When it reaches IMEM_TIMEOUT: fault<=1, go to HALT.
- Simultaneous events:
  - imem_rdy in the cycle of reset is ignored.
  - Halted together with Jump: Halted wins.
  - Branch with branch_cond=0 is sequential.

Optional Feature:
- Macro FETCH_INSTR_COUNT_EN.
- Defined:
  - Extra port retired_count out 32: counts ISSUE→FETCH transitions and the ISSUE→HALT transition.
  - Counter resets to 0 and saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h100, imem_rdy tied 1, no control → imem_addr sequence 0x100,0x104,0x108; instr_valid high every second cycle.
- ISSUE with Jump=1, instr=32'h0800_0040, pc=0x100 → next imem_addr=0x0000_0100.
- JR: Jump=JumpReg=1, jr_target=32'h0000_2003 → next imem_addr=0x2000.
- Branch: pc=0x200, instr[15:0]=16'hFFFE. branch_cond=1 → imem_addr=0x1FC; branch_cond=0 → 0x204.
- stall=1 for 5 cycles with Jump=1 → pc/instr unchanged; redirect only after stall drops. Halted=1 → halted=1, imem_req stays 0 for 20 cycles despite imem_rdy=1.
- IMEM_TIMEOUT=4, imem_rdy=0 → fault=1 and halted=1 after 4 FETCH cycles. pc=0xFFFF_FFFC sequential → next imem_addr=0. rst mid-FETCH → pc=RESET_PC next cycle.
